// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge-detection datapath.
package sobel_pkg;

    localparam int SOBEL_SUM_W   = 10;
    localparam int SOBEL_MAG_W   = 11;
    localparam int SOBEL_LATENCY = 3;

    localparam logic [7:0] SOBEL_SAT = 8'hFF;

    // Larger minus smaller, so the result never wraps.
    function automatic logic [SOBEL_SUM_W-1:0] abs_diff(
        input logic [SOBEL_SUM_W-1:0] a,
        input logic [SOBEL_SUM_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sobel_sync_delay.sv
// Fixed-depth shift register used to align frame sync with the datapath.
module sobel_sync_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sobel_edge_detect_8bit.sv
// 3-stage Sobel |Gx|+|Gy| magnitude, threshold bit and per-frame edge count.
module sobel_edge_detect_8bit
    import sobel_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480,
    parameter int         CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             matrix_frame_vsync,
    input  logic             matrix_frame_href,
    input  logic             matrix_frame_clken,
    input  logic [7:0]       matrix_p11,
    input  logic [7:0]       matrix_p12,
    input  logic [7:0]       matrix_p13,
    input  logic [7:0]       matrix_p21,
    input  logic [7:0]       matrix_p22,
    input  logic [7:0]       matrix_p23,
    input  logic [7:0]       matrix_p31,
    input  logic [7:0]       matrix_p32,
    input  logic [7:0]       matrix_p33,
    input  logic [7:0]       thresh,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [7:0]       post_img_mag,
    output logic             post_img_bit,
    output logic [CNT_W-1:0] edge_count
);

    if ((64'd1 << CNT_W) <= (64'(IMG_HDISP) * 64'(IMG_VDISP))) begin : g_bad_cnt_w
        $error("CNT_W too small for one frame of pixels");
    end

    localparam int W = SOBEL_SUM_W;

    logic [W-1:0] gx_p_q, gx_n_q, gy_p_q, gy_n_q;
    logic [W-1:0] gx_abs_q, gy_abs_q;
    logic [1:0]   href_q;
    logic [7:0]   mag_q, mag_d;
    logic         bit_q, bit_d;
    logic [SOBEL_MAG_W-1:0] sum;

    // p22 has zero weight in both kernels.
    logic [7:0] unused_p22;
    assign unused_p22 = matrix_p22;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_p_q   <= '0;
            gx_n_q   <= '0;
            gy_p_q   <= '0;
            gy_n_q   <= '0;
            gx_abs_q <= '0;
            gy_abs_q <= '0;
            href_q   <= '0;
            mag_q    <= '0;
            bit_q    <= 1'b0;
        end else begin
            gx_p_q   <= W'(matrix_p13) + {W'(matrix_p23), 1'b0} + W'(matrix_p33);
            gx_n_q   <= W'(matrix_p11) + {W'(matrix_p21), 1'b0} + W'(matrix_p31);
            gy_p_q   <= W'(matrix_p11) + {W'(matrix_p12), 1'b0} + W'(matrix_p13);
            gy_n_q   <= W'(matrix_p31) + {W'(matrix_p32), 1'b0} + W'(matrix_p33);
            gx_abs_q <= abs_diff(gx_p_q, gx_n_q);
            gy_abs_q <= abs_diff(gy_p_q, gy_n_q);
            href_q   <= {href_q[0], matrix_frame_href};
            mag_q    <= mag_d;
            bit_q    <= bit_d;
        end
    end

    // Threshold uses the full sum so values above 255 still compare correctly.
    always_comb begin
        mag_d = '0;
        bit_d = 1'b0;
        sum   = {1'b0, gx_abs_q} + {1'b0, gy_abs_q};
        if (href_q[1]) begin
            mag_d = (sum > SOBEL_MAG_W'(SOBEL_SAT)) ? SOBEL_SAT : sum[7:0];
            bit_d = (sum >= {3'b000, thresh});
        end
    end

    sobel_sync_delay #(
        .WIDTH(3),
        .DEPTH(SOBEL_LATENCY)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .data_i({matrix_frame_vsync, matrix_frame_href, matrix_frame_clken}),
        .data_o({post_frame_vsync, post_frame_href, post_frame_clken})
    );

    assign post_img_mag = mag_q;
    assign post_img_bit = bit_q;

    logic [CNT_W-1:0] acc_q, acc_d, cnt_q, cnt_d;
    logic             vsync_q, vsync_rise, hit;

    assign vsync_rise = post_frame_vsync & ~vsync_q;
    assign hit        = post_frame_href & post_frame_clken & bit_q;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (vsync_rise) begin
            cnt_d = acc_q;
            acc_d = CNT_W'(hit);
        end else if (hit && (acc_q != '1)) begin
            acc_d = acc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            vsync_q <= post_frame_vsync;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign edge_count = cnt_q;

endmodule

// File: tb/tb_sobel_edge_detect_8bit.sv
// Directed bench for sobel_edge_detect_8bit: values, latency, counter, reset.
module tb_sobel_edge_detect_8bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs, hr, ce;
    logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [7:0]  thresh;
    logic        o_vs, o_hr, o_ce, o_bit;
    logic [7:0]  o_mag;
    logic [18:0] o_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sobel_edge_detect_8bit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .matrix_frame_vsync(vs),
        .matrix_frame_href (hr),
        .matrix_frame_clken(ce),
        .matrix_p11        (p11),
        .matrix_p12        (p12),
        .matrix_p13        (p13),
        .matrix_p21        (p21),
        .matrix_p22        (p22),
        .matrix_p23        (p23),
        .matrix_p31        (p31),
        .matrix_p32        (p32),
        .matrix_p33        (p33),
        .thresh            (thresh),
        .post_frame_vsync  (o_vs),
        .post_frame_href   (o_hr),
        .post_frame_clken  (o_ce),
        .post_img_mag      (o_mag),
        .post_img_bit      (o_bit),
        .edge_count        (o_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mat(input logic [7:0] a11, a12, a13, a21, a22, a23, a31, a32, a33);
        p11 = a11; p12 = a12; p13 = a13;
        p21 = a21; p22 = a22; p23 = a23;
        p31 = a31; p32 = a32; p33 = a33;
    endtask

    task automatic uniform();
        set_mat(77, 77, 77, 77, 77, 77, 77, 77, 77);
    endtask

    task automatic step10();
        set_mat(0, 0, 10, 0, 0, 10, 0, 0, 10);
    endtask

    task automatic vsync_pulse();
        hr = 0; ce = 0; uniform();
        vs = 1; tick(); tick();
        vs = 0;
        repeat (4) tick();
    endtask

    // 4 lines x 8 pixels; mask bit l*8+p marks an edge pixel.
    task automatic run_frame(input logic [31:0] mask, input int prev, input int exp);
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                hr = 1; ce = 1;
                if (mask[l*8+p]) step10(); else uniform();
                tick();
            end
            hr = 0; ce = 0; uniform();
            tick(); tick();
        end
        repeat (4) tick();
        vs = 1; tick(); tick();
        vs = 0; tick();
        if (prev >= 0) chk("cnt_hold", 32'(o_cnt), prev);
        tick();
        chk("cnt_new", 32'(o_cnt), exp);
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 0; vs = 0; hr = 0; ce = 0; thresh = 1;
        uniform();
        #2;
        chk("rst_mag", 32'(o_mag), 0);
        chk("rst_bit", 32'(o_bit), 0);
        chk("rst_cnt", 32'(o_cnt), 0);
        chk("rst_sync", {29'd0, o_vs, o_hr, o_ce}, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        hr = 1; ce = 1; thresh = 1; uniform();
        repeat (4) tick();
        chk("uni_mag", 32'(o_mag), 0);
        chk("uni_bit", 32'(o_bit), 0);
        chk("uni_ce", 32'(o_ce), 1);

        step10(); thresh = 40;
        repeat (4) tick();
        chk("vedge_mag", 32'(o_mag), 40);
        chk("vedge_bit40", 32'(o_bit), 1);
        thresh = 41; tick();
        chk("vedge_bit41", 32'(o_bit), 0);
        chk("vedge_mag41", 32'(o_mag), 40);

        set_mat(0, 0, 100, 0, 0, 100, 0, 0, 100); thresh = 200;
        repeat (4) tick();
        chk("strong_mag", 32'(o_mag), 255);
        chk("strong_bit", 32'(o_bit), 1);

        set_mat(0, 0, 0, 0, 0, 0, 10, 10, 10); thresh = 40;
        repeat (4) tick();
        chk("hedge_mag", 32'(o_mag), 40);
        chk("hedge_bit", 32'(o_bit), 1);

        set_mat(0, 0, 100, 0, 0, 0, 0, 0, 0); thresh = 200;
        repeat (4) tick();
        chk("corner_mag", 32'(o_mag), 200);
        chk("corner_bit200", 32'(o_bit), 1);
        thresh = 201; tick();
        chk("corner_bit201", 32'(o_bit), 0);

        thresh = 40; hr = 1; ce = 0; uniform();
        repeat (4) tick();
        step10(); ce = 1; tick();
        chk("lat_c1", 32'(o_ce), 0);
        uniform(); ce = 0; tick();
        chk("lat_c2", 32'(o_ce), 0);
        tick();
        chk("lat_c3", 32'(o_ce), 1);
        chk("lat_mag", 32'(o_mag), 40);
        chk("lat_bit", 32'(o_bit), 1);
        tick();
        chk("lat_c4", 32'(o_ce), 0);
        chk("lat_mag4", 32'(o_mag), 0);

        hr = 0; ce = 1; step10();
        repeat (4) tick();
        chk("nohref_mag", 32'(o_mag), 0);
        chk("nohref_bit", 32'(o_bit), 0);
        chk("nohref_href", 32'(o_hr), 0);

        vsync_pulse();
        run_frame(32'h0, -1, 0);
        run_frame(32'h8100_2804, 0, 5);
        run_frame(32'h0, 5, 0);
        run_frame(32'h8100_2804, 0, 5);

        hr = 1; ce = 1; step10();
        repeat (4) tick();
        chk("pre_rst_mag", 32'(o_mag), 40);
        rst_n = 0; #1;
        chk("mid_rst_mag", 32'(o_mag), 0);
        chk("mid_rst_bit", 32'(o_bit), 0);
        chk("mid_rst_cnt", 32'(o_cnt), 0);
        chk("mid_rst_sync", {29'd0, o_vs, o_hr, o_ce}, 0);
        tick();
        rst_n = 1;
        tick();
        chk("rel_c1", 32'(o_ce), 0);
        tick();
        chk("rel_c2", 32'(o_ce), 0);
        tick();
        chk("rel_c3", 32'(o_ce), 1);
        chk("rel_mag", 32'(o_mag), 40);
        repeat (5) tick();
        chk("rel_cnt", 32'(o_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_edge_detect_8bit.md
# sobel_edge_detect_8bit

Downstream consumer of the 3x3 8-bit matrix generator in the grayscale edge-detection path. Each valid pixel's 3x3 neighbourhood gets the Sobel |Gx|+|Gy| magnitude, a saturated 8-bit magnitude and a binary edge bit against a runtime threshold. It also accumulates a per-frame edge-pixel count. Frame sync signals are delayed to match the 3-stage datapath, so outputs feed the display/bit-packing stage directly.

## Interface
- IMG_HDISP, 10'd640, active pixels per line (documentation/counter sizing only)
- IMG_VDISP, 10'd480, active lines per frame
- CNT_W, 19, edge counter width; must satisfy 2^CNT_W > IMG_HDISP*IMG_VDISP
- clk  input  1  pixel clock
- rst_n  input  1  reset; asynchronous, active-low
- matrix_frame_vsync  input  1  vsync aligned with the matrix (parent delays it to match the matrix generator)
- matrix_frame_href  input  1  href aligned with the matrix
- matrix_frame_clken  input  1  pixel-valid aligned with the matrix
- matrix_pRC (R,C = 1..3)  input  8 each  neighbourhood; R = row (1 = oldest line), C = column (1 = oldest pixel)
- thresh  input  8  edge threshold; quasi-static, change only during vertical blanking
- post_frame_vsync  output  1  matrix_frame_vsync delayed 3 clk
- post_frame_href  output  1  matrix_frame_href delayed 3 clk
- post_frame_clken  output  1  matrix_frame_clken delayed 3 clk
- post_img_mag  output  8  min(|Gx|+|Gy|, 255)
- post_img_bit  output  1  1 when |Gx|+|Gy| >= thresh
- edge_count  output  CNT_W  edge pixels in the last completed frame

## Operation
- Gx = (p13 + 2·p23 + p33) − (p11 + 2·p21 + p31). Gy = (p11 + 2·p12 + p13) − (p31 + 2·p32 + p33).
- Stage 1 registers four unsigned 10-bit partial sums: gx_p, gx_n, gy_p, gy_n (max 1020 each).
- Stage 2 registers |gx_p − gx_n| and |gy_p − gy_n|, 10 bits each. Subtract larger minus smaller; no signed wrap.
- Stage 3 forms the 11-bit sum (max 2040) and registers:
  - post_img_mag = sum > 255 ? 255 : sum[7:0]
  - post_img_bit = (sum >= {3'b0, thresh}); the comparison uses the full 11-bit sum, not the saturated value.
- Stage 3 forces mag and bit to 0 whenever the stage-2-delayed href is 0.
- The datapath advances every clk, with no stall. Results are meaningful only when post_frame_clken = 1. Held matrix inputs during clken gaps reproduce identical results.
- Edge counter (counts post_* signals):
  - acc increments when post_frame_href & post_frame_clken & post_img_bit.
  - On a rising edge of post_frame_vsync (detected with a 1-clk registered copy): edge_count <= acc, and acc <= 0, or 1 if an edge pixel qualifies in that same cycle.
  - acc saturates at all-ones and does not wrap.
- The block has no border handling. Edge pixels from the matrix generator's zeroed/garbage first rows and columns are processed as-is.

## Timing
- Latency: 3 clk, matrix input to post_img_*. Sync outputs use the same 3-clk delay, so alignment is exact.
- Reset clears all pipeline registers, sync delays, the vsync edge detector, acc and edge_count. Every output resets to 0.
- Reset asserted mid-frame: outputs are 0 immediately (asynchronous). After release, the first valid output appears 3 clk after the first post-reset matrix_frame_clken. The partial frame is counted from 0.
- thresh is sampled combinationally in stage 3. A change takes effect on results registered from the next clk edge.
- edge_count updates once per frame, one clk after the post_frame_vsync rising edge, and is stable for the rest of the frame.

## Structure
- Shared package sobel_pkg holds:
  - SOBEL_SUM_W = 10, SOBEL_MAG_W = 11, SOBEL_LATENCY = 3
  - the 8'hFF saturation constant
- Sub-module sobel_sync_delay:
  - parameterised width/depth shift register with async reset
  - one instance of 3 bits x depth SOBEL_LATENCY for vsync, href and clken
- Datapath and counter stay in the top module.

## Test plan
- Uniform field (all pRC = 77, href = clken = 1, thresh = 1) -> mag = 0, bit = 0 on every valid output.
- Vertical edge, columns [0 0 10] on all rows -> Gx = 40, Gy = 0. mag = 40. bit = 1 at thresh = 40; bit = 0 at thresh = 41.
- Strong edge, columns [0 0 100] on all rows -> sum = 400, mag = 255 (saturated). bit = 1 at thresh = 200.
- Latency/alignment: single clken pulse with the step pattern at cycle N -> post_frame_clken = 1 and mag valid exactly at cycle N+3. href low during input -> mag = bit = 0.
- Counter: frame of 4 lines x 8 pixels with 5 edge pixels, then vsync rising edge -> edge_count = 5 the following clk. The next frame with 0 edges -> edge_count = 0.
- rst_n pulsed low mid-line -> all outputs 0 during reset. After release the stream resumes with 3-clk latency and edge_count = 0 until the next vsync.
